matrix_sequencer: RTL and testbench



---
 rtl/matrix_pkg.sv | 21 ++
 rtl/mseq_counter.sv | 40 ++++
 rtl/matrix_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_matrix_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared MatrixCore definitions: sequencer state encoding and array dimensions
// used by both the sequencer and the MatrixCore datapath.
package matrix_pkg;

   localparam int MATRIX_ROW_SIZE    = 16;
   localparam int MATRIX_COLUMN_SIZE = 16;

   typedef enum logic [2:0] {
      MSEQ_IDLE     = 3'd0,
      MSEQ_LOAD     = 3'd1,
      MSEQ_WAIT_SET = 3'd2,
      MSEQ_COMPUTE  = 3'd3,
      MSEQ_DRAIN    = 3'd4,
      MSEQ_DONE     = 3'd5
   } mseq_state_t;

   function automatic logic mseq_is_busy(input mseq_state_t s);
      return (s != MSEQ_IDLE);
   endfunction

endpackage

// File: rtl/mseq_counter.sv
// Clear/increment counter with a terminal-count flag compared against a
// runtime value, so the same block serves fixed and job-dependent limits.
module mseq_counter #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] tc_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear has priority over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {W{1'b0}};
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/matrix_sequencer.sv
// Control FSM sequencing one MatrixCore job: row load, set-flag wait, and one
// or more column passes. Optional busy-cycle counter under MSEQ_PERF_CNT_EN.
module matrix_sequencer
   import matrix_pkg::*;
#(
   parameter int ROW_SIZE    = MATRIX_ROW_SIZE,
   parameter int COLUMN_SIZE = MATRIX_COLUMN_SIZE,
   parameter int PASS_W      = 4,
   parameter int SET_TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [PASS_W-1:0] passes,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              error,
   input  logic              row_valid,
   output logic              row_ready,
   output logic              rb_enable,
   output logic              rb_dendFlag,
   input  logic              rb_dsetFlag,
   output logic              mm_columnEnable,
   output logic              uj_selector
`ifdef MSEQ_PERF_CNT_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   localparam int ROW_W = $clog2(ROW_SIZE + 1);
   localparam int COL_W = $clog2(COLUMN_SIZE + 1);
   localparam int TMO_W = $clog2(SET_TIMEOUT + 1);
   localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

   mseq_state_t       state_q, state_d;
   logic [PASS_W-1:0] passes_q, passes_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              col_en_q, col_en_d;
   logic              sel_q, sel_d;

   logic row_clr_s, row_tc_s;
   logic col_clr_s, col_inc_s, col_tc_s;
   logic pass_clr_s, pass_inc_s, pass_tc_s;
   logic tmo_clr_s, tmo_inc_s, tmo_tc_s;

   assign row_ready   = (state_q == MSEQ_LOAD);
   assign rb_enable   = row_valid & row_ready;
   assign rb_dendFlag = rb_enable & row_tc_s;

   // Each counter is cleared whenever it is outside its owning state.
   assign row_clr_s  = (state_q != MSEQ_LOAD) | abort | (rb_enable & row_tc_s);
   assign col_clr_s  = (state_q != MSEQ_COMPUTE) | abort | col_tc_s;
   assign col_inc_s  = (state_q == MSEQ_COMPUTE);
   assign pass_clr_s = (state_q == MSEQ_IDLE) | (state_q == MSEQ_DONE) | abort;
   assign pass_inc_s = (state_q == MSEQ_DRAIN);
   assign tmo_clr_s  = (state_q != MSEQ_WAIT_SET) | abort | rb_dsetFlag;
   assign tmo_inc_s  = (state_q == MSEQ_WAIT_SET);

   mseq_counter #(.W(ROW_W)) u_row_cnt (
      .clk_i    (clock),
      .rst_ni   (reset),
      .clr_i    (row_clr_s),
      .inc_i    (rb_enable),
      .tc_val_i (ROW_W'(ROW_SIZE - 1)),
      .tc_o     (row_tc_s)
   );

   mseq_counter #(.W(COL_W)) u_col_cnt (
      .clk_i    (clock),
      .rst_ni   (reset),
      .clr_i    (col_clr_s),
      .inc_i    (col_inc_s),
      .tc_val_i (COL_W'(COLUMN_SIZE - 1)),
      .tc_o     (col_tc_s)
   );

   mseq_counter #(.W(PASS_W)) u_pass_cnt (
      .clk_i    (clock),
      .rst_ni   (reset),
      .clr_i    (pass_clr_s),
      .inc_i    (pass_inc_s),
      .tc_val_i (passes_q - PASS_ONE),
      .tc_o     (pass_tc_s)
   );

   mseq_counter #(.W(TMO_W)) u_tmo_cnt (
      .clk_i    (clock),
      .rst_ni   (reset),
      .clr_i    (tmo_clr_s),
      .inc_i    (tmo_inc_s),
      .tc_val_i (TMO_W'(SET_TIMEOUT - 1)),
      .tc_o     (tmo_tc_s)
   );

   // Next-state logic; abort takes priority in every non-idle state.
   always_comb begin
      state_d  = state_q;
      passes_d = passes_q;
      error_d  = 1'b0;
      case (state_q)
         MSEQ_IDLE: begin
            if (start) begin
               state_d  = MSEQ_LOAD;
               passes_d = (passes == {PASS_W{1'b0}}) ? PASS_ONE : passes;
            end else begin
               state_d = MSEQ_IDLE;
            end
         end
         MSEQ_LOAD: begin
            if (abort) begin
               state_d = MSEQ_IDLE;
            end else if (rb_enable && row_tc_s) begin
               state_d = MSEQ_WAIT_SET;
            end else begin
               state_d = MSEQ_LOAD;
            end
         end
         MSEQ_WAIT_SET: begin
            if (abort) begin
               state_d = MSEQ_IDLE;
            end else if (rb_dsetFlag) begin
               state_d = MSEQ_COMPUTE;
            end else if (tmo_tc_s) begin
               state_d = MSEQ_IDLE;
               error_d = 1'b1;
            end else begin
               state_d = MSEQ_WAIT_SET;
            end
         end
         MSEQ_COMPUTE: begin
            if (abort) begin
               state_d = MSEQ_IDLE;
            end else if (col_tc_s) begin
               state_d = MSEQ_DRAIN;
            end else begin
               state_d = MSEQ_COMPUTE;
            end
         end
         MSEQ_DRAIN: begin
            if (abort) begin
               state_d = MSEQ_IDLE;
            end else if (pass_tc_s) begin
               state_d = MSEQ_DONE;
            end else begin
               state_d = MSEQ_COMPUTE;
            end
         end
         MSEQ_DONE: begin
            state_d = MSEQ_IDLE;
         end
         default: begin
            state_d = MSEQ_IDLE;
         end
      endcase
   end

   // Registered outputs are decoded from the next state so they align with it.
   always_comb begin
      busy_d   = mseq_is_busy(state_d);
      done_d   = (state_d == MSEQ_DONE);
      col_en_d = (state_d == MSEQ_COMPUTE);
      if (state_d != MSEQ_COMPUTE) begin
         sel_d = 1'b0;
      end else if (state_q == MSEQ_COMPUTE) begin
         sel_d = sel_q;
      end else begin
         sel_d = (state_q == MSEQ_DRAIN);
      end
   end

   // State, latched pass count and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= MSEQ_IDLE;
         passes_q <= {PASS_W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         col_en_q <= 1'b0;
         sel_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         passes_q <= passes_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         col_en_q <= col_en_d;
         sel_q    <= sel_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign mm_columnEnable = col_en_q;
   assign uj_selector     = sel_q;

`ifdef MSEQ_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;

   // Busy-cycle count: cleared by an accepted start, saturating, held when idle.
   always_comb begin
      perf_d = perf_q;
      if ((state_q == MSEQ_IDLE) && start) begin
         perf_d = 32'd0;
      end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end else begin
         perf_d = perf_q;
      end
   end

   // Performance counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_q <= 32'd0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_matrix_sequencer.sv
// Directed self-checking bench for matrix_sequencer (ROW/COLUMN = 16).
module tb_matrix_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] passes = 4'd1;
   logic       abort = 1'b0;
   logic       busy, done, error;
   logic       row_valid = 1'b0;
   logic       row_ready, rb_enable, rb_dendFlag;
   logic       rb_dsetFlag = 1'b0;
   logic       mm_columnEnable, uj_selector;
`ifdef MSEQ_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   always #5 clock = ~clock;

   matrix_sequencer #(.ROW_SIZE(16), .COLUMN_SIZE(16), .PASS_W(4), .SET_TIMEOUT(255)) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .passes          (passes),
      .abort           (abort),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .row_valid       (row_valid),
      .row_ready       (row_ready),
      .rb_enable       (rb_enable),
      .rb_dendFlag     (rb_dendFlag),
      .rb_dsetFlag     (rb_dsetFlag),
      .mm_columnEnable (mm_columnEnable),
      .uj_selector     (uj_selector)
`ifdef MSEQ_PERF_CNT_EN
      ,
      .perf_cycles     (perf_cycles)
`endif
   );

   int checks = 0;
   int passed = 0;

   int cyc = 0;
   int start_at = -1, start2_at = -1, abort_at = -1;
   int rv_mode = 0;
   bit dset_never = 1'b0;
   bit dset_req = 1'b0;

   int   n_en, n_dend, dend_beat, first_en, last_beat;
   int   nb;
   int   burst_len [8];
   int   burst_first [8];
   int   burst_last [8];
   logic burst_sel [8];
   bit   sel_toggle, prev_col;
   int   n_done, done_cyc, n_err, err_cyc;
   logic busy_at_err, busy_after_err, busy_after_abort, col_after_abort;

   task automatic clear_obs();
      n_en = 0; n_dend = 0; dend_beat = -1; first_en = -1; last_beat = -1;
      nb = 0; sel_toggle = 1'b0; prev_col = 1'b0;
      n_done = 0; done_cyc = -1; n_err = 0; err_cyc = -1;
      busy_at_err = 1'bx; busy_after_err = 1'bx;
      busy_after_abort = 1'bx; col_after_abort = 1'bx;
      dset_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         burst_len[i] = 0; burst_first[i] = -1; burst_last[i] = -1; burst_sel[i] = 1'b0;
      end
   endtask

   // One clock: drive inputs 1 time unit after the edge, observe 1 unit later.
   task automatic cycle();
      @(posedge clock);
      #1;
      cyc++;
      start       = (cyc == start_at) || (cyc == start2_at);
      abort       = (cyc == abort_at);
      row_valid   = (rv_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      rb_dsetFlag = dset_req;
      dset_req    = 1'b0;
      #1;
      if (rb_enable) begin
         n_en++;
         if (first_en < 0) first_en = cyc;
         last_beat = cyc;
      end
      if (rb_dendFlag) begin
         n_dend++;
         dend_beat = n_en;
         if (!dset_never) dset_req = 1'b1;
      end
      if (mm_columnEnable) begin
         if (!prev_col && nb < 8) begin
            burst_sel[nb] = uj_selector;
            burst_first[nb] = cyc;
            nb++;
         end
         if (nb > 0) begin
            burst_len[nb-1]++;
            burst_last[nb-1] = cyc;
            if (uj_selector !== burst_sel[nb-1]) sel_toggle = 1'b1;
         end
      end
      prev_col = mm_columnEnable;
      if (done) begin n_done++; done_cyc = cyc; end
      if (error) begin n_err++; err_cyc = cyc; busy_at_err = busy; end
      if (n_err > 0 && cyc == err_cyc + 1) busy_after_err = busy;
      if (abort_at > 0 && cyc == abort_at + 1) begin
         busy_after_abort = busy;
         col_after_abort = mm_columnEnable;
      end
   endtask

   task automatic run_job(input int np, input int max_cyc, input int extra);
      passes = 4'(np);
      clear_obs();
      start_at = cyc + 1;
      for (int i = 0; i < max_cyc; i++) begin
         cycle();
         if (n_done > 0 || n_err > 0) break;
      end
      for (int i = 0; i < extra; i++) cycle();
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      checks++; if ({busy, done, error, row_ready, rb_enable, rb_dendFlag, mm_columnEnable, uj_selector} !== 8'd0)
         $display("FAIL reset_outputs: got %b want 00000000", {busy, done, error, row_ready, rb_enable, rb_dendFlag, mm_columnEnable, uj_selector}); else passed++;
      cycle(); cycle();
      reset = 1'b1;
      cycle();
      checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
      checks++; if (row_ready !== 1'b0) $display("FAIL idle_row_ready: got %b want 0", row_ready); else passed++;
`ifdef MSEQ_PERF_CNT_EN
      checks++; if (perf_cycles !== 32'd0) $display("FAIL reset_perf: got %0d want 0", perf_cycles); else passed++;
`endif
   endtask

   task automatic test_basic_job();
      run_job(1, 200, 2);
      checks++; if (first_en !== start_at + 1) $display("FAIL basic_first_ready: got cyc %0d want %0d", first_en, start_at + 1); else passed++;
      checks++; if (n_en !== 16) $display("FAIL basic_rb_enable: got %0d want 16", n_en); else passed++;
      checks++; if (n_dend !== 1 || dend_beat !== 16) $display("FAIL basic_dend: got %0d at beat %0d want 1 at 16", n_dend, dend_beat); else passed++;
      checks++; if (nb !== 1 || burst_len[0] !== 16) $display("FAIL basic_burst: got %0d bursts len %0d want 1 len 16", nb, burst_len[0]); else passed++;
      checks++; if (burst_first[0] !== last_beat + 2) $display("FAIL basic_dset_to_col: got cyc %0d want %0d", burst_first[0], last_beat + 2); else passed++;
      checks++; if (burst_sel[0] !== 1'b0) $display("FAIL basic_selector: got %b want 0", burst_sel[0]); else passed++;
      checks++; if (n_done !== 1 || done_cyc !== burst_last[0] + 2) $display("FAIL basic_done: got %0d at %0d want 1 at %0d", n_done, done_cyc, burst_last[0] + 2); else passed++;
      checks++; if (done_cyc - start_at !== 35) $display("FAIL basic_latency: got %0d want 35", done_cyc - start_at); else passed++;
`ifdef MSEQ_PERF_CNT_EN
      checks++; if (perf_cycles !== 32'd35) $display("FAIL basic_perf: got %0d want 35", perf_cycles); else passed++;
`endif
   endtask

   task automatic test_multi_pass();
      run_job(3, 300, 2);
      checks++; if (nb !== 3) $display("FAIL multi_bursts: got %0d want 3", nb); else passed++;
      checks++; if (burst_len[0] !== 16 || burst_len[1] !== 16 || burst_len[2] !== 16)
         $display("FAIL multi_lengths: got %0d %0d %0d want 16 16 16", burst_len[0], burst_len[1], burst_len[2]); else passed++;
      checks++; if ({burst_sel[0], burst_sel[1], burst_sel[2]} !== 3'b011)
         $display("FAIL multi_selector: got %b%b%b want 011", burst_sel[0], burst_sel[1], burst_sel[2]); else passed++;
      checks++; if (burst_first[1] - burst_last[0] !== 2 || burst_first[2] - burst_last[1] !== 2)
         $display("FAIL multi_gap: got %0d %0d want 2 2", burst_first[1] - burst_last[0], burst_first[2] - burst_last[1]); else passed++;
      checks++; if (sel_toggle !== 1'b0) $display("FAIL multi_sel_stable: got toggle %b want 0", sel_toggle); else passed++;
      checks++; if (n_done !== 1 || done_cyc - start_at !== 69) $display("FAIL multi_latency: got %0d done at +%0d want 1 at +69", n_done, done_cyc - start_at); else passed++;
   endtask

   task automatic test_row_stall();
      rv_mode = 1;
      run_job(0, 400, 2);
      rv_mode = 0;
      checks++; if (n_en !== 16) $display("FAIL stall_rb_enable: got %0d want 16", n_en); else passed++;
      checks++; if (n_dend !== 1 || dend_beat !== 16) $display("FAIL stall_dend: got %0d at beat %0d want 1 at 16", n_dend, dend_beat); else passed++;
      checks++; if (nb !== 1 || n_done !== 1) $display("FAIL stall_pass0_as_1: got %0d bursts %0d done want 1 1", nb, n_done); else passed++;
   endtask

   task automatic test_timeout();
      dset_never = 1'b1;
      run_job(1, 400, 2);
      dset_never = 1'b0;
      checks++; if (err_cyc - last_beat !== 256) $display("FAIL tmo_delay: got %0d want 256", err_cyc - last_beat); else passed++;
      checks++; if (n_err !== 1) $display("FAIL tmo_pulse: got %0d cycles want 1", n_err); else passed++;
      checks++; if (busy_at_err !== 1'b0 || busy_after_err !== 1'b0) $display("FAIL tmo_busy: got %b %b want 0 0", busy_at_err, busy_after_err); else passed++;
      checks++; if (n_done !== 0 || nb !== 0) $display("FAIL tmo_no_done: got done %0d bursts %0d want 0 0", n_done, nb); else passed++;
   endtask

   task automatic test_abort();
      abort_at = cyc + 1 + 40;
      run_job(4, 60, 0);
      checks++; if (nb !== 2 || burst_len[1] !== 6) $display("FAIL abort_burst: got %0d bursts len %0d want 2 len 6", nb, burst_len[1]); else passed++;
      checks++; if (col_after_abort !== 1'b0 || busy_after_abort !== 1'b0) $display("FAIL abort_drop: got col %b busy %b want 0 0", col_after_abort, busy_after_abort); else passed++;
      checks++; if (n_done !== 0) $display("FAIL abort_no_done: got %0d want 0", n_done); else passed++;
      abort_at = -1;
      run_job(1, 200, 2);
      checks++; if (nb !== 1 || burst_sel[0] !== 1'b0) $display("FAIL abort_rerun_sel: got %0d bursts sel %b want 1 sel 0", nb, burst_sel[0]); else passed++;
      checks++; if (n_done !== 1 || done_cyc - start_at !== 35) $display("FAIL abort_rerun_done: got %0d at +%0d want 1 at +35", n_done, done_cyc - start_at); else passed++;
   endtask

   task automatic test_reset_midjob();
      passes = 4'd1;
      clear_obs();
      start_at = cyc + 1;
      repeat (6) cycle();
      checks++; if (row_ready !== 1'b1) $display("FAIL mid_in_load: got %b want 1", row_ready); else passed++;
      #2 reset = 1'b0;
      #1;
      checks++; if ({busy, row_ready, rb_enable, rb_dendFlag, mm_columnEnable} !== 5'd0)
         $display("FAIL mid_async_drop: got %b want 00000", {busy, row_ready, rb_enable, rb_dendFlag, mm_columnEnable}); else passed++;
      cycle(); cycle();
      checks++; if ({busy, row_ready, rb_enable} !== 3'd0) $display("FAIL mid_held: got %b want 000", {busy, row_ready, rb_enable}); else passed++;
      reset = 1'b1;
      cycle();
      checks++; if (busy !== 1'b0 || row_ready !== 1'b0) $display("FAIL mid_idle_after: got %b %b want 0 0", busy, row_ready); else passed++;
      run_job(2, 300, 2);
      checks++; if (n_en !== 16 || nb !== 2) $display("FAIL mid_fresh_job: got %0d beats %0d bursts want 16 2", n_en, nb); else passed++;
      checks++; if (done_cyc - start_at !== 52) $display("FAIL mid_latency: got %0d want 52", done_cyc - start_at); else passed++;
`ifdef MSEQ_PERF_CNT_EN
      checks++; if (perf_cycles !== 32'd52) $display("FAIL mid_perf: got %0d want 52", perf_cycles); else passed++;
`endif
   endtask

   task automatic test_start_in_done();
      start2_at = cyc + 1 + 35;
      run_job(1, 200, 5);
      start2_at = -1;
      checks++; if (done_cyc !== start_at + 35) $display("FAIL sid_done_cyc: got %0d want %0d", done_cyc, start_at + 35); else passed++;
      checks++; if (n_en !== 16 || busy !== 1'b0) $display("FAIL sid_ignored: got %0d beats busy %b want 16 0", n_en, busy); else passed++;
   endtask

   initial begin
      clear_obs();
      test_reset();
      test_basic_job();
      test_multi_pass();
      test_row_stall();
      test_timeout();
      test_abort();
      test_reset_midjob();
      test_start_in_done();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
